// File: rtl/count_arbiter.sv
// Round-robin arbiter that grants one requester at a time for a requested
// number of cycles, timed by a shared up-counter, with cancel on request drop.
module count_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] len,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         count,
    output logic [1:0]                    dbg_state
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Handshake: req[i] is a level held by requester i for as long as it wants
    // service; grant[i] stays high from LOAD through DONE, done[i] pulses once
    // in DONE. Dropping req[idx] before DONE cancels the transaction.

    state_t                  state, state_nx;
    logic [IW-1:0]           ptr, ptr_nx;
    logic [IW-1:0]           idx, idx_nx;
    logic [IW-1:0]           idx_inc;
    logic [IW-1:0]           win;
    logic                    found;
    logic [DATA_WIDTH-1:0]   len_q, len_nx, len_sel;
    logic [DATA_WIDTH-1:0]   cnt, cnt_nx;

    // First pass takes the lowest requester at or above ptr; the second pass
    // wraps around to the lowest requester below ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IW'(i) >= ptr)) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end

    always_comb begin
        len_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                len_sel = len[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign idx_inc = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        idx_nx   = idx;
        len_nx   = len_q;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    idx_nx   = win;
                    len_nx   = len_sel;
                    cnt_nx   = '0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (!req[idx]) begin
                    state_nx = IDLE;
                    ptr_nx   = idx_inc;
                end else begin
                    cnt_nx   = '0;
                    state_nx = (len_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req[idx]) begin
                    state_nx = IDLE;
                    ptr_nx   = idx_inc;
                end else begin
                    // Final RUN cycle lifts count to len, so the counter never wraps.
                    cnt_nx = cnt + 1'b1;
                    if (cnt == len_q - 1'b1) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                ptr_nx   = idx_inc;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            idx   <= '0;
            len_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            idx   <= idx_nx;
            len_q <= len_nx;
            cnt   <= cnt_nx;
        end
    end

    // Outputs decode only flopped state, so they clear the instant reset asserts.
    assign busy      = (state != IDLE);
    assign grant     = busy ? (NUM_REQ'(1) << idx) : '0;
    assign done      = (state == DONE) ? (NUM_REQ'(1) << idx) : '0;
    assign count     = cnt;
    assign dbg_state = state;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed bench for count_arbiter: a transaction-timeline model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_count_arbiter;

    localparam int DW = 4;
    localparam int NR = 4;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] len;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;
    logic [DW-1:0]   count;
    logic [1:0]      dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    count_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count     (count),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Timeline model: a transaction starting at edge n occupies cycles t=1..L+2
    // after it; count = max(0, t-2); done in cycle t=L+2; req drop ends it early.
    logic          m_active;
    int            m_t, m_w, m_L, m_ptr, m_count;

    always @(posedge clk or negedge rst) begin
        int a, t, w, l, p, c, cand;
        bit fnd;
        if (!rst) begin
            m_active <= 1'b0;
            m_t <= 0; m_w <= 0; m_L <= 0; m_ptr <= 0; m_count <= 0;
        end else begin
            a = m_active; t = m_t; w = m_w; l = m_L; p = m_ptr; c = m_count;
            if (a == 0) begin
                fnd = 1'b0;
                for (int o = 0; o < NR; o++) begin
                    cand = (p + o) % NR;
                    if (!fnd && req[cand]) begin
                        fnd = 1'b1;
                        w = cand;
                    end
                end
                if (fnd) begin
                    a = 1; t = 1; c = 0;
                    l = int'(len[w*DW +: DW]);
                end
            end else if (t == l + 2 || !req[w]) begin
                a = 0;
                p = (w + 1) % NR;
            end else begin
                t = t + 1;
                c = (t > 2) ? t - 2 : 0;
            end
            m_active <= (a != 0);
            m_t <= t; m_w <= w; m_L <= l; m_ptr <= p; m_count <= c;
        end
    end

    // scoreboard compare, every cycle
    always @(negedge clk) begin
        logic [NR-1:0] e_grant, e_done;
        e_grant = m_active ? NR'(1 << m_w) : '0;
        e_done  = (m_active && m_t == m_L + 2) ? NR'(1 << m_w) : '0;
        chk("model_grant", 32'(grant), 32'(e_grant));
        chk("model_done",  32'(done),  32'(e_done));
        chk("model_busy",  32'(busy),  32'(m_active));
        chk("model_count", 32'(count), 32'(m_count));
        chk("onehot_grant", 32'($onehot0(grant)), 32'd1);
        chk("done_in_grant", 32'((done == 0) || (done == grant)), 32'd1);
    end

    logic [3:0] rr_exp [5];
    logic [3:0] cnt_exp [5];
    int         done_tally [NR];

    initial begin
        rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cnt_exp = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        rst = 1'b0;
        req = '0;
        len = '0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // single request, len0=3; later len/req edits must not disturb it
        @(negedge clk);
        len = 16'h0003;
        req = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 5) begin
                chk("single_grant", 32'(grant), 32'h1);
                chk("single_count", 32'(count), 32'(cnt_exp[k]));
                chk("single_done",  32'(done),  (k == 4) ? 32'h1 : 32'h0);
            end else begin
                chk("single_busy_after",  32'(busy),  32'd0);
                chk("single_count_hold",  32'(count), 32'd3);
            end
            if (k == 1) begin
                len = 16'h000F;
                req = 4'b0101;
            end
            if (k == 4) req = 4'b0000;
        end

        // round-robin, all len=1, from a fresh pointer
        reset_pulse();
        req = 4'b1111;
        len = 16'h1111;
        for (int i = 0; i < NR; i++) done_tally[i] = 0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if ((c - 1) % 4 == 0) chk("rr_grant", 32'(grant), 32'(rr_exp[(c - 1) / 4]));
            for (int i = 0; i < NR; i++) if (done[i]) done_tally[i]++;
            if (c == 19) req = 4'b0000;
        end
        chk("rr_done0", 32'(done_tally[0]), 32'd2);
        chk("rr_done1", 32'(done_tally[1]), 32'd1);
        chk("rr_done2", 32'(done_tally[2]), 32'd1);
        chk("rr_done3", 32'(done_tally[3]), 32'd1);

        // zero length on requester 2
        @(negedge clk);
        req = 4'b0100;
        len = 16'h0000;
        @(negedge clk);
        chk("zero_load_grant", 32'(grant), 32'h4);
        chk("zero_load_done",  32'(done),  32'h0);
        @(negedge clk);
        chk("zero_done_grant", 32'(grant), 32'h4);
        chk("zero_done_done",  32'(done),  32'h4);
        chk("zero_done_count", 32'(count), 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("zero_idle_busy", 32'(busy), 32'd0);

        // cancel: requester 1, len=5, dropped in the 3rd RUN cycle
        req = 4'b0010;
        len = 16'h0050;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("cancel_grant", 32'(grant), 32'h2);
            if (c >= 2) chk("cancel_count", 32'(count), 32'(c - 2));
            if (c == 2) len = 16'h0090;
            if (c == 4) req = 4'b0000;
        end
        @(negedge clk);
        chk("cancel_grant_clr", 32'(grant), 32'h0);
        chk("cancel_no_done",   32'(done),  32'h0);
        chk("cancel_count_hold", 32'(count), 32'd2);
        req = 4'b0111;
        len = 16'h0200;
        @(negedge clk);
        chk("cancel_next_rr", 32'(grant), 32'h4);

        // asynchronous reset mid-RUN, between edges
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_count", 32'(count), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_done",  32'(done),  32'd0);
        chk("arst_busy",  32'(busy),  32'd0);
        chk("arst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1001;
        @(negedge clk);
        chk("arst_ptr0_win", 32'(grant), 32'h1);
        req = 4'b0000;
        @(negedge clk);

        // max length on requester 3 with mid-run len/req noise
        req = 4'b1000;
        len = 16'hF000;
        for (int t = 1; t <= 18; t++) begin
            @(negedge clk);
            if (t <= 17) begin
                chk("max_grant", 32'(grant), 32'h8);
                chk("max_count", 32'(count), (t <= 2) ? 32'd0 : 32'(t - 2));
                chk("max_done",  32'(done),  (t == 17) ? 32'h8 : 32'h0);
            end else begin
                chk("max_idle_busy",  32'(busy),  32'd0);
                chk("max_count_hold", 32'(count), 32'd15);
            end
            if (t == 3) begin
                len = 16'h2000;
                req = 4'b1001;
            end
            if (t == 17) req = 4'b0000;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/count_arbiter.md
COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, meaning the width of each duration field and of the shared counter.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: asynchronous and active-low.
REQ-005 The block SHALL have port req, input, NUM_REQ, per-requester request level, bit i for requester i.
REQ-006 The block SHALL have port len, input, NUM_REQ*DATA_WIDTH, per-requester duration in cycles; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port grant, output, NUM_REQ, registered one-hot (or all-zero) grant.
REQ-008 The block SHALL have port done, output, NUM_REQ, registered one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 The block SHALL have port count, output, DATA_WIDTH, current value of the shared up-counter.

Function
REQ-011 The block SHALL contain one shared up-counter (step 1, synchronous load of 0, enable) and an FSM with states IDLE, LOAD, RUN, DONE.
REQ-012 The block SHALL keep a round-robin pointer ptr (0..NUM_REQ-1); in IDLE it SHALL select the first asserted req bit searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
REQ-013 IDLE: with no req asserted, state SHALL stay IDLE, grant=0, count holds; with any req asserted, the block SHALL latch winner index idx and len[idx] and go to LOAD on the next edge.
REQ-014 LOAD: grant[idx]=1, counter loaded to 0; next state SHALL be DONE if latched len==0, else RUN.
REQ-015 RUN: counter SHALL increment by 1 each cycle (count=k in k-th RUN cycle, k from 0); RUN SHALL last exactly len cycles, exiting to DONE when count==len-1.
REQ-016 DONE: grant[idx]=1, done[idx]=1 for exactly this one cycle, count==latched len (0 if len==0); next state SHALL be IDLE and ptr SHALL become (idx+1) mod NUM_REQ.
REQ-017 Latency: req first sampled high in IDLE at edge n SHALL give LOAD after edge n, done pulse in the cycle after edge n+len+1, IDLE again after edge n+len+2.
REQ-018 Cancel: if req[idx] is low while in LOAD or RUN, the next state SHALL be IDLE, no done pulse, grant cleared, ptr=(idx+1) mod NUM_REQ, count holding its value.
REQ-019 Changes on len or on non-granted req bits after latching SHALL NOT affect the current transaction.
REQ-020 len = 2^DATA_WIDTH-1 SHALL complete without counter wrap; count SHALL never wrap within a transaction.
REQ-021 At most one grant bit and at most one done bit SHALL be high in any cycle; done bit SHALL equal the grant bit when high.
REQ-022 A requester holding req high through DONE SHALL compete again in the following IDLE cycle under the updated ptr.

Reset
REQ-023 While rst is low the block SHALL immediately force state=IDLE, ptr=0, latched idx/len=0, count=0, grant=0, done=0, busy=0, independent of clk.
REQ-024 Reset asserted mid-transaction SHALL abort it without a done pulse; after rst rises the first IDLE arbitration SHALL start from ptr=0.

Verification
REQ-025 Single request: req=0001, len0=3 -> grant=0001 for 5 cycles, count 0,0,1,2,3, done=0001 in the 5th cycle only, busy low afterward.
REQ-026 Round-robin: req=1111 held, all len=1 -> grant sequence 0001,0010,0100,1000,0001, each done pulse once per turn.
REQ-027 Zero length: req=0100, len2=0 -> LOAD then DONE, done=0100 in the 2nd grant cycle, count=0.
REQ-028 Cancel: req=0010, len1=5, drop req1 in 3rd RUN cycle -> grant cleared next edge, no done, next arbitration starts at requester 2.
REQ-029 Async reset: rst low mid-RUN between clock edges -> grant/done/busy/count 0 without a clock edge; after release, req=1001 -> requester 0 wins.
REQ-030 Max length: DATA_WIDTH=4, len=15 -> RUN 15 cycles, count reaches 15 in DONE, no wrap to 0 before done.
